mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_mem_pkg.sv | 19 +
 rtl/mem_arbiter_arb_pick.sv | 40 ++++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared widths, FSM states and owner encoding for the CPU memory arbiter.
package cpu_mem_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between the fetch (bit 0) and data (bit 1) ports.
// Define MEM_ARB_RR_EN for round-robin; otherwise the data port has fixed priority.
module arb_pick
  import cpu_mem_pkg::*;
(
  input  logic [1:0] eligible,
  input  owner_e     last_owner,
  output logic       gnt_valid,
  output owner_e     gnt_owner
);

  // Pick a winner; on conflict the configured policy decides.
  always_comb begin
    gnt_valid = |eligible;
    gnt_owner = OWN_IF;
    case (eligible)
      2'b01: gnt_owner = OWN_IF;
      2'b10: gnt_owner = OWN_D;
      2'b11: begin
`ifdef MEM_ARB_RR_EN
        if (last_owner == OWN_IF) begin
          gnt_owner = OWN_D;
        end else begin
          gnt_owner = OWN_IF;
        end
`else
        gnt_owner = OWN_D;
`endif
      end
      default: gnt_owner = OWN_IF;
    endcase
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority has no history input.
  logic unused_last_owner_s;
  assign unused_last_owner_s = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a read-only fetch port and a load/store port onto one sync-read RAM.
// Define MEM_ARB_RR_EN for round-robin conflict resolution (default: data wins).
module mem_arbiter
  import cpu_mem_pkg::*;
(
  input  logic              clkb,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  state_e              state_r;
  owner_e              owner_r;
  logic                busy_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                ram_en_r;
  logic                ram_we_r;
  logic [DATA_W-1:0]   if_rdata_r;
  logic [DATA_W-1:0]   d_rdata_r;
  logic                if_ack_r;
  logic                d_ack_r;

  logic [1:0]          eligible_s;
  logic                gnt_valid_s;
  owner_e              gnt_owner_s;
  owner_e              last_owner_s;

  // A port whose ack is high this cycle is still holding the request it was just served for.
  assign eligible_s = {d_req & ~d_ack_r, if_req & ~if_ack_r};

`ifdef MEM_ARB_RR_EN
  owner_e last_r;

  // Round-robin history: the most recently granted port.
  always_ff @(posedge clkb or posedge rst) begin
    if (rst) begin
      last_r <= OWN_IF;
    end else if ((state_r == IDLE) && gnt_valid_s) begin
      last_r <= gnt_owner_s;
    end else begin
      last_r <= last_r;
    end
  end

  assign last_owner_s = last_r;
`else
  assign last_owner_s = OWN_IF;
`endif

  arb_pick u_pick (
    .eligible   (eligible_s),
    .last_owner (last_owner_s),
    .gnt_valid  (gnt_valid_s),
    .gnt_owner  (gnt_owner_s)
  );

  // Access sequencer: grant in IDLE, drive the RAM for one cycle, return data and ack.
  always_ff @(posedge clkb or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      owner_r    <= OWN_IF;
      busy_r     <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      ram_en_r   <= 1'b0;
      ram_we_r   <= 1'b0;
      if_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r  <= {DATA_W{1'b0}};
      if_ack_r   <= 1'b0;
      d_ack_r    <= 1'b0;
    end else begin
      if_ack_r <= 1'b0;
      d_ack_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            state_r  <= ACCESS;
            busy_r   <= 1'b1;
            owner_r  <= gnt_owner_s;
            ram_en_r <= 1'b1;
            if (gnt_owner_s == OWN_D) begin
              addr_r   <= d_addr;
              wdata_r  <= d_wdata;
              ram_we_r <= d_we;
            end else begin
              addr_r   <= if_addr;
              wdata_r  <= {DATA_W{1'b0}};
              ram_we_r <= 1'b0;
            end
          end else begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            ram_en_r <= 1'b0;
            ram_we_r <= 1'b0;
          end
        end
        ACCESS: begin
          state_r  <= DONE;
          ram_en_r <= 1'b0;
          ram_we_r <= 1'b0;
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          // Writes also capture ram_rdata; the requester treats it as don't-care.
          if (owner_r == OWN_D) begin
            d_rdata_r <= ram_rdata;
            d_ack_r   <= 1'b1;
          end else begin
            if_rdata_r <= ram_rdata;
            if_ack_r   <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          ram_en_r <= 1'b0;
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign ram_en    = ram_en_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = addr_r;
  assign ram_wdata = wdata_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign if_ack    = if_ack_r;
  assign d_ack     = d_ack_r;
  assign busy      = busy_r;
  assign owner     = owner_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a 128x32 synchronous-read RAM model.
module tb_mem_arbiter;
  import cpu_mem_pkg::*;

  logic              clkb = 1'b0;
  logic              rst;
  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] if_rdata, d_rdata;
  logic              if_ack, d_ack;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              busy, owner;

  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        cmp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acks = 0;
  int   last_ack_cyc = 0;
  logic auto_drop = 1'b1;

  always #5 clkb = ~clkb;

  mem_arbiter dut (
    .clkb(clkb), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .owner(owner)
  );

  // RAM model; the preload port is only used while the arbiter is held in reset.
  always @(posedge clkb) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1ns after the edge; acks are matched against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clkb);
    #1;
    cyc++;
    chk("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
    if (if_ack || d_ack) begin
      acks++;
      last_ack_cyc = cyc;
      chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ack_port", 32'(d_ack), 32'(e.port));
        if (e.cmp) chk("ack_rdata", d_ack ? d_rdata : if_rdata, e.data);
      end
      if (auto_drop) begin
        if (d_ack) d_req = 1'b0;
        if (if_ack) if_req = 1'b0;
      end
    end
  endtask

  task automatic preload(input logic [6:0] addr, input logic [31:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    @(posedge clkb);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic run_single(input logic port, input logic we, input logic [6:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_data,
                            input logic cmp, input string tag);
    int start_cyc;
    int start_acks;
    exp_q.push_back('{port: port, data: exp_data, cmp: cmp});
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    start_cyc = cyc;
    start_acks = acks;
    step();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_owner"}, 32'(owner), 32'(port));
    chk({tag, "_ram_en"}, 32'(ram_en), 32'd1);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'(port & we));
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(addr));
    if (we) chk({tag, "_ram_wdata"}, ram_wdata, wdata);
    for (int i = 0; i < 8 && acks == start_acks; i++) begin
      step();
      if (!we) chk({tag, "_no_write"}, 32'(ram_we), 32'd0);
    end
    chk({tag, "_latency"}, 32'(cyc - start_cyc), 32'd3);
    step();
  endtask

  // Both ports request together: data read of 0x7F and fetch of 0x05.
  task automatic run_conflict(input logic first, input string tag);
    int a_cyc;
    int start_acks;
    if (first) begin
      exp_q.push_back('{port: 1'b1, data: 32'h12345678, cmp: 1'b1});
      exp_q.push_back('{port: 1'b0, data: 32'hDEADBEEF, cmp: 1'b1});
    end else begin
      exp_q.push_back('{port: 1'b0, data: 32'hDEADBEEF, cmp: 1'b1});
      exp_q.push_back('{port: 1'b1, data: 32'h12345678, cmp: 1'b1});
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 7'h7F;
    if_req = 1'b1; if_addr = 7'h05;
    start_acks = acks;
    a_cyc = 0;
    for (int i = 0; i < 16 && (acks - start_acks) < 2; i++) begin
      step();
      if ((acks - start_acks) == 1 && a_cyc == 0) a_cyc = cyc;
    end
    chk({tag, "_acks"}, 32'(acks - start_acks), 32'd2);
    chk({tag, "_gap"}, 32'(last_ack_cyc - a_cyc), 32'd3);
    step();
  endtask

  initial begin
    int          start_acks;
    int          ack_c [4];
    logic [6:0]  busy_h;
    logic [6:0]  ack_h;

    rst = 1'b1;
    if_req = 1'b0; if_addr = 7'h00;
    d_req = 1'b0; d_we = 1'b0; d_addr = 7'h00; d_wdata = 32'h0;
    pl_en = 1'b0; pl_addr = 7'h00; pl_data = 32'h0;

    preload(7'h05, 32'hDEADBEEF);
    preload(7'h10, 32'hA5A5A5A5);
    preload(7'h7F, 32'h00000000);
    preload(7'h00, 32'h00000000);

    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_acks", 32'({if_ack, d_ack}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;

    // Reset while a write to 0x10 is in ACCESS.
    d_req = 1'b1; d_we = 1'b1; d_addr = 7'h10; d_wdata = 32'h11111111;
    step();
    chk("abort_ram_en_before", 32'(ram_en), 32'd1);
    chk("abort_ram_we_before", 32'(ram_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ram_en_async", 32'(ram_en), 32'd0);
    chk("abort_ram_we_async", 32'(ram_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("abort_mem_unchanged", mem[7'h10], 32'hA5A5A5A5);
    chk("abort_no_ack", 32'(d_ack), 32'd0);

    run_single(1'b0, 1'b0, 7'h05, 32'h0, 32'hDEADBEEF, 1'b1, "fetch05");
    run_single(1'b1, 1'b1, 7'h7F, 32'h12345678, 32'h0, 1'b0, "write7f");
    chk("write7f_mem", mem[7'h7F], 32'h12345678);
    chk("write7f_no_wrap", mem[7'h00], 32'h00000000);
    run_single(1'b1, 1'b0, 7'h7F, 32'h0, 32'h12345678, 1'b1, "read7f");
    chk("hold_if_rdata", if_rdata, 32'hDEADBEEF);
    run_single(1'b0, 1'b0, 7'h05, 32'h0, 32'hDEADBEEF, 1'b1, "fetch05b");
    chk("hold_d_rdata", d_rdata, 32'h12345678);
    run_single(1'b1, 1'b1, 7'h00, 32'hCAFEF00D, 32'h0, 1'b0, "write00");
    run_single(1'b0, 1'b0, 7'h00, 32'h0, 32'hCAFEF00D, 1'b1, "fetch00");

    // Last grant was fetch: data wins under either policy.
    run_conflict(1'b1, "conflict_after_if");
    // Last grant was data: only round-robin hands the conflict to fetch.
    run_single(1'b1, 1'b0, 7'h7F, 32'h0, 32'h12345678, 1'b1, "read7f_b");
`ifdef MEM_ARB_RR_EN
    run_conflict(1'b0, "conflict_after_d");
`else
    run_conflict(1'b1, "conflict_after_d");
`endif

    // Both requests held across four grants from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    auto_drop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back('{port: 1'b1, data: 32'h12345678, cmp: 1'b1});
      else exp_q.push_back('{port: 1'b0, data: 32'hDEADBEEF, cmp: 1'b1});
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 7'h7F;
    if_req = 1'b1; if_addr = 7'h05;
    start_acks = acks;
    for (int i = 0; i < 24 && (acks - start_acks) < 4; i++) begin
      step();
      if ((if_ack || d_ack) && (acks - start_acks) <= 4) ack_c[acks - start_acks - 1] = cyc;
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("held4_acks", 32'(acks - start_acks), 32'd4);
    for (int i = 1; i < 4; i++) chk("held4_gap", 32'(ack_c[i] - ack_c[i-1]), 32'd3);
    step();
    step();
    step();

    // Fetch request held across its ack with the data port idle.
    exp_q.push_back('{port: 1'b0, data: 32'hDEADBEEF, cmp: 1'b1});
    exp_q.push_back('{port: 1'b0, data: 32'hDEADBEEF, cmp: 1'b1});
    if_req = 1'b1; if_addr = 7'h05;
    for (int i = 0; i < 7; i++) begin
      step();
      busy_h[i] = busy;
      ack_h[i]  = if_ack;
    end
    if_req = 1'b0;
    auto_drop = 1'b1;
    chk("held_if_busy", 32'(busy_h), 32'(7'b0110011));
    chk("held_if_ack", 32'(ack_h), 32'(7'b1000100));
    step();
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
